// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a 4-stage register pipeline.
// Drives operand-forwarding selects, load-use bubbles, front-end flushes after
// a taken jump and a full-pipeline freeze while data memory is busy. It also
// keeps a saturating stall-cycle counter.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   id_r2/id_r3, id_use_r2/3    decode-stage sources and their read enables
//   ex_*, mem_*, wb_*           destination/control fields of ID/EX, EX/MEM, MEM/WB
//   ex_jmp_taken                jump resolved taken in EX
//   mem_ready                   data memory finishes its access this cycle
//   clr_cnt                     synchronous clear of stall_cnt
//   hold_front, hold_all        hold PC+IF/ID, hold PC+all pipeline registers
//   bubble_ex, flush_front      NOP into ID/EX, clear IF/ID
//   fwd_a, fwd_b                0 regfile, 1 EX/MEM ALU result, 2 MEM/WB result
//   state                       0 RUN, 1 LDSTALL, 2 FLUSH
//   stall_cnt                   saturating stall-cycle count
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_r2,
    input  logic [REG_W-1:0] id_r3,
    input  logic             id_use_r2,
    input  logic             id_use_r3,
    input  logic [REG_W-1:0] ex_destr,
    input  logic             ex_wreg,
    input  logic             ex_rmem,
    input  logic [REG_W-1:0] mem_destr,
    input  logic             mem_wreg,
    input  logic             mem_rmem,
    input  logic             mem_wmem,
    input  logic [REG_W-1:0] wb_destr,
    input  logic             wb_wreg,
    input  logic             ex_jmp_taken,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic             hold_front,
    output logic             hold_all,
    output logic             bubble_ex,
    output logic             flush_front,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned     FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             mem_busy;
    logic             load_use;

    // Freeze condition; gated so everything reads idle while reset is held.
    assign mem_busy = rst & (mem_rmem | mem_wmem) & ~mem_ready;

    assign load_use = ex_rmem & ex_wreg &
                      ((id_use_r2 & (ex_destr == id_r2)) |
                       (id_use_r3 & (ex_destr == id_r3)));

    // MEM beats WB; a load in EX/MEM has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] r, input logic use_r);
        if (use_r && mem_wreg && !mem_rmem && (mem_destr == r)) begin
            return 2'd1;
        end else if (use_r && wb_wreg && (wb_destr == r)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign fwd_a = rst ? fwd_sel(id_r2, id_use_r2) : 2'd0;
    assign fwd_b = rst ? fwd_sel(id_r3, id_use_r3) : 2'd0;

    // State and flush-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic; nothing advances while memory is busy.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (!mem_busy) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_jmp_taken) begin
                        // The jump cycle itself is the first flush cycle.
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = FC_INIT;
                        end
                    end else if (load_use) begin
                        state_d = ST_LDSTALL;
                    end
                end
                ST_LDSTALL: state_d = ST_RUN;
                ST_FLUSH: begin
                    if (fcnt_q <= FC_W'(1)) begin
                        state_d = ST_RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - FC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    // Pipeline control outputs from current state and inputs.
    always_comb begin
        hold_front  = 1'b0;
        hold_all    = mem_busy;
        bubble_ex   = 1'b0;
        flush_front = 1'b0;
        if (rst && !mem_busy) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_jmp_taken) begin
                        flush_front = 1'b1;
                        bubble_ex   = 1'b1;
                    end else if (load_use) begin
                        hold_front = 1'b1;
                        bubble_ex  = 1'b1;
                    end
                end
                ST_LDSTALL: begin
                    hold_front = 1'b1;
                    bubble_ex  = 1'b1;
                end
                ST_FLUSH: begin
                    flush_front = 1'b1;
                    bubble_ex   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (clr_cnt) begin
            stall_cnt_q <= '0;
        end else if ((hold_front || hold_all) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 4-stage register pipeline (ID/EX, EX/MEM and MEM/WB pipeline registers).
- Compares decode-stage source registers against destinations held in downstream pipeline registers and drives operand-forwarding selects.
- Inserts load-use bubbles, flushes wrong-path instructions after a taken jump, and freezes the whole pipeline while data memory is busy.
- Keeps a saturating stall counter for performance measurement.

## Interface
Parameters:
- REG_W, 4, register-index width
- CNT_W, 16, stall counter width
- FLUSH_CYCLES, 1, cycles of front-end flush per taken jump (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- id_r2, id_r3  in  REG_W  source registers of the instruction in decode
- id_use_r2, id_use_r3  in  1  the corresponding source register is actually read
- ex_destr  in  REG_W  destination register held in ID/EX (DestR_2)
- ex_wreg, ex_rmem  in  1  ID/EX register-write and memory-read flags
- mem_destr  in  REG_W  destination register held in EX/MEM
- mem_wreg, mem_rmem, mem_wmem  in  1  EX/MEM control flags
- wb_destr  in  REG_W  destination register held in MEM/WB
- wb_wreg  in  1  MEM/WB register-write flag
- ex_jmp_taken  in  1  jump resolved taken in EX this cycle
- mem_ready  in  1  data memory completes the access this cycle
- clr_cnt  in  1  synchronous clear of stall_cnt
- hold_front  out  1  hold PC and IF/ID
- hold_all  out  1  hold PC and all pipeline registers
- bubble_ex  out  1  load NOP (all control bits zero) into ID/EX
- flush_front  out  1  clear IF/ID
- fwd_a, fwd_b  out  2  operand select: 0 register file, 1 EX/MEM ALU result, 2 MEM/WB result
- state  out  2  0 RUN, 1 LDSTALL, 2 FLUSH
- stall_cnt  out  CNT_W  saturating stall-cycle count

## Operation
- Register 0 is an ordinary register with no hardwired zero. Index matches are plain equality.
- **Forwarding (combinational):**
  - fwd_a = 1 if id_use_r2, mem_wreg, !mem_rmem and mem_destr==id_r2.
  - Otherwise fwd_a = 2 if id_use_r2, wb_wreg and wb_destr==id_r2.
  - Otherwise fwd_a = 0.
  - fwd_b uses the same rules with r3.
  - The MEM stage has priority over the WB stage. Load data is never forwarded from EX/MEM.
- **mem_busy** = (mem_rmem | mem_wmem) & !mem_ready.
- **hold_all = mem_busy**, in every state. While hold_all=1:
  - hold_front, bubble_ex and flush_front are 0.
  - state, the flush counter and all pending actions are frozen.
- **load_use** = ex_rmem & ex_wreg & ((id_use_r2 & ex_destr==id_r2) | (id_use_r3 & ex_destr==id_r3)).
- **FSM** (evaluated only when hold_all=0):
  - **RUN**
    - If ex_jmp_taken: flush_front=1 and bubble_ex=1 this cycle. Go to FLUSH with count=FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES=1. Jump wins over a simultaneous load_use.
    - Else if load_use: hold_front=1 and bubble_ex=1; go to LDSTALL.
    - Else all controls are 0.
  - **LDSTALL:** hold_front=1 and bubble_ex=1 for exactly this cycle, then RUN. ex_jmp_taken is ignored here because EX holds a bubble. On return to RUN the load sits in MEM/WB and is forwarded with select 2.
  - **FLUSH:** flush_front=1 and bubble_ex=1. The counter decrements each cycle; return to RUN when the counter reaches 0. ex_jmp_taken is ignored.
- **stall_cnt:**
  - Increments on every cycle where hold_front|hold_all, saturating at 2^CNT_W-1.
  - clr_cnt forces it to 0 on the next edge; clr_cnt has priority over the increment.
- **Reset (rst=0):**
  - state=RUN, flush counter=0, stall_cnt=0.
  - hold_front, hold_all, bubble_ex, flush_front and fwd_a/fwd_b are all forced to 0 while reset is held.

## Timing
- fwd_*, hold_*, bubble_ex and flush_front are combinational from the current state and inputs. They are valid in the same cycle and are consumed by the pipeline registers at the next rising clk.
- **Load-use penalty:** exactly 2 bubbles. The detection cycle is in RUN, the second cycle is in LDSTALL, and the dependent instruction issues in cycle 3.
- **Jump penalty:** FLUSH_CYCLES cycles of flush, beginning in the cycle ex_jmp_taken is seen.
- **Memory wait:** hold_all stays asserted for every cycle in which mem_ready=0, and deasserts in the cycle mem_ready=1.
  - A mem_busy arriving in LDSTALL or FLUSH extends that state by exactly the wait length.
- **Reset released mid-operation:** the controller starts in RUN with no pending stall or flush.

## Test plan
- **Forwarding priority:** id_r2=5, id_use_r2=1, mem_destr=5, mem_wreg=1, wb_destr=5, wb_wreg=1 → fwd_a=1. Then set mem_rmem=1 (with mem_ready=1) → fwd_a=2.
- **Load-use:** ex_rmem=1, ex_wreg=1, ex_destr=7, id_r3=7, id_use_r3=1 → hold_front=1 and bubble_ex=1 for 2 cycles, state RUN→LDSTALL→RUN, stall_cnt=2.
- **Jump with FLUSH_CYCLES=2, plus simultaneous load_use:** ex_jmp_taken=1 → flush_front=1 for 2 cycles, hold_front=0 throughout, state passes through FLUSH.
- **Memory wait inside LDSTALL:** mem_rmem=1, mem_ready=0 for 3 cycles → hold_all=1 for 3 cycles, state stays LDSTALL. Then 1 more LDSTALL cycle, then RUN. stall_cnt=5.
- **Saturation and clear:** CNT_W=4 with hold_all held for 20 cycles → stall_cnt=15. Then clr_cnt=1 → 0.
- **Reset during FLUSH:** rst=0 asynchronously → all control outputs 0 immediately, state=RUN. After release with idle inputs, no flush occurs.
